// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encodings and default operand width for the serial adder
package serial_adder_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial LSB-first adder, one full-adder cell, valid/ready handshakes.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t          r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_work, r_sum;
  logic [IW-1:0]   r_idx;
  logic            r_carry, r_cout;
  logic            w_s, w_co, w_accept, w_last;
  fa_cell u_fa (
    .a (r_a[r_idx]),
    .b (r_b[r_idx]),
    .ci(r_carry),
    .s (w_s),
    .co(w_co)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_accept = (r_state == IDLE) && start_valid;
    w_last   = (r_state == RUN) && (r_idx == IW'(WIDTH - 1));
    w_next   = (r_state == RUN)  ? (w_last ? DONE : RUN) :
               (r_state == DONE) ? (res_ready ? IDLE : DONE) :
               (start_valid ? RUN : IDLE);
  end
  // r_work collects bits during RUN; r_sum only changes at the final edge so the last result holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_work[r_idx] <= w_s;
      r_carry       <= w_co;
      r_idx         <= w_last ? '0 : r_idx + IW'(1);
      if (w_last) begin
        r_sum  <= {w_s, r_work[WIDTH-2:0]};
        r_cout <= w_co;
      end
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_carry ^ w_co;
  end
  assign ovf = r_ovf;
`endif
  assign start_ready = (r_state == IDLE);
  assign res_valid   = (r_state == DONE);
  assign busy        = (r_state == RUN) || (r_state == DONE);
  assign sum         = r_sum;
  assign cout        = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vector table plus handshake, hold, reset-abort and scramble sequences
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;
  vec_t vecs[7];
  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .sum        (sum),
    .cout       (cout),
    .busy       (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run_op(input vec_t v, input bit scramble, input bit early_ready, input int hold);
    int n;
    logic [7:0] prev;
    prev = sum;
    @(negedge clk);
    chk("start_ready_idle", start_ready, 1);
    a = v.a;
    b = v.b;
    cin = v.cin;
    start_valid = 1'b1;
    res_ready = early_ready;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      chk("sum_hold_run", sum, prev);
      if (scramble) begin
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        start_valid = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    start_valid = 1'b0;
    chk("latency", n, 8);
    chk("sum", sum, v.sum);
    chk("cout", cout, v.cout);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", ovf, v.ovf);
`endif
    chk("busy_done", busy, 1);
    chk("start_ready_done", start_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = 8'hFF;
      b = 8'hFF;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_sum", sum, v.sum);
      chk("hold_cout", cout, v.cout);
      chk("hold_start_ready", start_ready, 0);
    end
    @(negedge clk);
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("res_valid_clear", res_valid, 0);
    chk("busy_idle", busy, 0);
    chk("sum_hold_idle", sum, v.sum);
    @(posedge clk);
    #1;
    chk("sum_hold_idle2", sum, v.sum);
  endtask
  initial begin
    bit seen;
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
    #2;
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start_ready", start_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) run_op(vecs[i], 1'b0, 1'b0, 0);
    run_op('{8'h3C, 8'h3C, 1'b0, 8'h78, 1'b0, 1'b0}, 1'b0, 1'b0, 5);
    run_op('{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1}, 1'b1, 1'b1, 0);
    // abort at idx==3: accept edge, then three processing edges
    @(negedge clk);
    a = 8'hF0;
    b = 8'h0F;
    cin = 1'b1;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_start_ready", start_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_start_ready", start_ready, 1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("abort_ovf", ovf, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (res_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0);
    run_op('{8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0}, 1'b0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start_valid  input  1  operand request valid.
REQ-005 start_ready  output  1  controller can accept a request.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 cin  input  1  initial carry-in.
REQ-009 res_valid  output  1  result valid.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  result A+B+cin, modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 busy  output  1  high in RUN and DONE.

Function
REQ-014 The block SHALL compute the WIDTH-bit sum bit-serially, LSB first, using exactly one 1-bit full-adder cell, one bit per clock.
REQ-015 FSM states: IDLE, RUN, DONE; no other reachable states.
REQ-016 IDLE: start_ready=1; on start_valid&&start_ready, capture a, b, cin into internal registers, clear bit index to 0, go to RUN.
REQ-017 RUN: each cycle feeds a_reg[idx], b_reg[idx], carry_reg to the cell; writes cell sum into sum_reg[idx]; carry_reg <= cell carry; idx increments.
REQ-018 RUN to DONE on the edge that processes idx==WIDTH-1; cout <= final carry on that same edge.
REQ-019 Latency: res_valid SHALL assert exactly WIDTH rising edges after the accepting edge.
REQ-020 DONE: res_valid=1; sum and cout stable; on res_ready go to IDLE; if res_ready is low, hold indefinitely.
REQ-021 start_ready SHALL be 0 in RUN and DONE; no back-to-back overlap, min. request spacing WIDTH+1 cycles.
REQ-022 a, b, cin, start_valid SHALL be ignored outside the IDLE accepting edge; mid-RUN changes do not affect the result.
REQ-023 sum/cout SHALL hold the last result in IDLE until the next result overwrites them.
REQ-024 res_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 reset=1 SHALL immediately force IDLE, idx=0, carry_reg=0, sum=0, cout=0, res_valid=0, busy=0, start_ready=1 (ovf=0 if present).
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation; no res_valid follows.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN: when defined, add output ovf (1 bit) = carry into MSB XOR carry out of MSB, registered with cout, valid while res_valid; when undefined, port ovf and its logic SHALL NOT exist.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-029 One sub-module, fa_cell: combinational 1-bit full adder (a, b, ci -> s, co); instantiated once.

Verification (WIDTH=8)
REQ-030 a=8'h0F, b=8'h01, cin=0 -> res_valid 8 edges after accept, sum=8'h10, cout=0.
REQ-031 a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1 (full carry ripple, wrap-around); with SERIAL_ADDER_OVF_EN, ovf=0.
REQ-032 a=8'h7F, b=8'h01, cin=0 with SERIAL_ADDER_OVF_EN -> sum=8'h80, cout=0, ovf=1.
REQ-033 Hold res_ready=0 for 5 cycles in DONE -> res_valid, sum, cout stable; start_ready=0 throughout; new start_valid ignored.
REQ-034 Assert reset at RUN idx=3 -> outputs at reset values same cycle; after release, new request a=8'h22, b=8'h11 -> sum=8'h33.
REQ-035 Change a, b every cycle during RUN -> result equals sum of the operands captured at accept.
